// File: rtl/can_arb_tx_serializer.sv
// Purpose: serializes SOF + CAN arbitration/ID field (std or ext) onto tx with bit stuffing,
//          checking rx at each sample point for arbitration loss and bit errors.
// Latency: tx is registered (changes on the tx_pt edge); done/arb_lost/bit_err one cycle after sp.
// Backpressure: none; start is accepted only in IDLE, strobes outside the expected phase are ignored.
module can_arb_tx_serializer #(
    parameter int STUFF_LEN = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_pt,
    input  logic        sp,
    input  logic        start,
    input  logic        ide,
    input  logic        rtr,
    input  logic [10:0] id_base,
    input  logic [17:0] id_ext,
    input  logic        rx,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        arb_lost,
    output logic        bit_err,
    output logic        run_bit,
    output logic [2:0]  run_len
);

    // Frame sequencing states
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_TX = 2'd1;
    localparam logic [1:0] S_DRIVE   = 2'd2;
    localparam logic [1:0] S_SAMPLE  = 2'd3;

    // Payload lengths including SOF
    localparam logic [5:0] STD_BITS = 6'd14;
    localparam logic [5:0] EXT_BITS = 6'd33;

    logic [1:0]  state_q,    state_d;
    logic [32:0] frame_q,    frame_d;     // payload bits, MSB = SOF, sent from bit 32 downward
    logic [5:0]  nbits_q,    nbits_d;     // number of payload bits in this frame
    logic [5:0]  idx_q,      idx_d;       // index of the next payload bit to drive
    logic        stuff_q,    stuff_d;     // bit currently on the line is a stuff bit
    logic        tx_q,       tx_d;
    logic        done_q,     done_d;
    logic        arb_q,      arb_d;
    logic        berr_q,     berr_d;
    logic        run_bit_q,  run_bit_d;
    logic [2:0]  run_len_q,  run_len_d;

    logic [32:0] frame_new;
    logic        pay_bit;
    logic        stuff_due;
    logic        last_payload;
    logic        err_arb;
    logic        err_bit;

    // Assemble the payload image from the request inputs (used only at start accept)
    always_comb begin
        frame_new = 33'd0;
        if (ide) begin
            // SOF, base ID, SRR=1, IDE=1, extended ID, RTR
            frame_new = {1'b0, id_base, 1'b1, 1'b1, id_ext, rtr};
        end else begin
            // SOF, base ID, RTR, IDE=0; remaining positions never sent
            frame_new = {1'b0, id_base, rtr, 1'b0, 19'd0};
        end
    end

    // Per-bit decode: next payload bit, stuffing need, and sample-point error conditions
    always_comb begin
        pay_bit      = frame_q[6'd32 - idx_q];
        stuff_due    = (run_len_q == 3'(STUFF_LEN));
        last_payload = !stuff_q && (idx_q == nbits_q);
        // Recessive sent but dominant read on an arbitration bit: another node wins.
        // SOF is dominant, so a recessive payload bit is always after SOF.
        err_arb      = tx_q && !rx && !stuff_q;
        // Dominant sent but recessive read, or a recessive stuff bit overwritten.
        err_bit      = (!tx_q && rx) || (tx_q && !rx && stuff_q);
    end

    // Next-state logic for the frame sequencer and line/stuff state
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        nbits_d   = nbits_q;
        idx_d     = idx_q;
        stuff_d   = stuff_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        arb_d     = 1'b0;
        berr_d    = 1'b0;
        run_bit_d = run_bit_q;
        run_len_d = run_len_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    frame_d   = frame_new;
                    nbits_d   = ide ? EXT_BITS : STD_BITS;
                    idx_d     = 6'd0;
                    stuff_d   = 1'b0;
                    run_bit_d = 1'b1;
                    run_len_d = 3'd0;
                    state_d   = S_WAIT_TX;
                end
            end

            S_WAIT_TX: begin
                // SOF opens a fresh run of dominant bits
                if (tx_pt) begin
                    tx_d      = 1'b0;
                    run_bit_d = 1'b0;
                    run_len_d = 3'd1;
                    stuff_d   = 1'b0;
                    idx_d     = 6'd1;
                    state_d   = S_DRIVE;
                end
            end

            S_DRIVE: begin
                if (sp) begin
                    if (err_arb) begin
                        arb_d   = 1'b1;
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end else if (err_bit) begin
                        berr_d  = 1'b1;
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end else if (last_payload) begin
                        // tx keeps the last bit; the downstream serializer takes over the line
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SAMPLE;
                    end
                end
            end

            S_SAMPLE: begin
                if (tx_pt) begin
                    if (stuff_due) begin
                        tx_d      = ~run_bit_q;
                        run_bit_d = ~run_bit_q;
                        run_len_d = 3'd1;
                        stuff_d   = 1'b1;
                    end else begin
                        tx_d      = pay_bit;
                        run_bit_d = pay_bit;
                        run_len_d = (pay_bit == run_bit_q) ? run_len_q + 3'd1 : 3'd1;
                        stuff_d   = 1'b0;
                        idx_d     = idx_q + 6'd1;
                    end
                    state_d = S_DRIVE;
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset forces the line recessive immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            frame_q   <= 33'd0;
            nbits_q   <= 6'd0;
            idx_q     <= 6'd0;
            stuff_q   <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            arb_q     <= 1'b0;
            berr_q    <= 1'b0;
            run_bit_q <= 1'b1;
            run_len_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            nbits_q   <= nbits_d;
            idx_q     <= idx_d;
            stuff_q   <= stuff_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            arb_q     <= arb_d;
            berr_q    <= berr_d;
            run_bit_q <= run_bit_d;
            run_len_q <= run_len_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign arb_lost = arb_q;
    assign bit_err  = berr_q;
    assign run_bit  = run_bit_q;
    assign run_len  = run_len_q;

endmodule
